// File: rtl/npu_seq_ctrl_if.sv
// npu_seq_ctrl_if: load, core and result channels of the NPU job sequencer
interface npu_seq_ctrl_if #(
  parameter int DEPTH = 8,
  parameter int ACC_W = 8
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic load_valid;
  logic load_ready;
  logic [3:0] load_data;
  logic [3:0] load_weight;
  logic load_last;
  logic core_start;
  logic [3:0] core_input;
  logic [3:0] core_weight;
  logic [3:0] core_output;
  logic core_done;
  logic res_valid;
  logic res_ready;
  logic [ACC_W-1:0] res_data;
  logic [CW-1:0] res_count;
  logic err_timeout;
  modport slave (
    input load_valid, load_data, load_weight, load_last, core_output, core_done, res_ready,
    output load_ready, core_start, core_input, core_weight, res_valid, res_data, res_count, err_timeout
  );
  modport master (
    output load_valid, load_data, load_weight, load_last, core_output, core_done, res_ready,
    input load_ready, core_start, core_input, core_weight, res_valid, res_data, res_count, err_timeout
  );
endinterface

// File: rtl/npu_seq_ctrl.sv
// npu_seq_ctrl: buffers a job of input/weight pairs, feeds them to the NPU core one at a time and accumulates the results
module npu_seq_ctrl #(
  parameter int DEPTH = 8,
  parameter int ACC_W = 8,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst_n,
  npu_seq_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] RESULT = 3'd4;
  logic [2:0] state;
  logic [7:0] mem [DEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] idx;
  logic [7:0] timer;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0] sum;
  logic err;
  logic accept;
  logic timed_out;
  logic op_end;
  logic in_res;
  logic in_op;
  logic [7:0] cur;
  assign accept = bus.load_ready && bus.load_valid;
  assign cur = mem[idx[AW-1:0]];
  assign sum = {1'b0, acc} + {{(ACC_W-3){1'b0}}, bus.core_output};
  assign timed_out = state == WAIT && !bus.core_done && timer == 8'(TIMEOUT - 1);
  assign op_end = state == WAIT && (bus.core_done || timed_out);
  assign in_res = rst_n && state == RESULT;
  assign in_op = state == ISSUE || state == WAIT;
  assign bus.load_ready = rst_n && (state == IDLE || state == LOAD);
  assign bus.core_start = rst_n && state == ISSUE;
  assign bus.core_input = in_op ? cur[7:4] : 4'd0;
  assign bus.core_weight = in_op ? cur[3:0] : 4'd0;
  assign bus.res_valid = in_res;
  assign bus.res_data = in_res ? acc : '0;
  assign bus.res_count = in_res ? count : '0;
  assign bus.err_timeout = err;
  // pair buffer: written only on an accepted load handshake, no reset needed
  always_ff @(posedge clk)
    if (accept) mem[state == IDLE ? '0 : count[AW-1:0]] <= {bus.load_data, bus.load_weight};
  // job sequencer: load, issue/wait per pair with timeout, then hold the result
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      idx <= '0;
      count <= '0;
      timer <= '0;
      err <= 1'b0;
    end else
      case (state)
        IDLE: if (accept) begin
          count <= CW'(1);
          err <= 1'b0;
          state <= bus.load_last ? ISSUE : LOAD;
        end
        LOAD: if (accept) begin
          count <= count + 1'b1;
          state <= (bus.load_last || count == CW'(DEPTH - 1)) ? ISSUE : LOAD;
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (bus.core_done) acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
          if (timed_out) err <= 1'b1;
          if (op_end) begin
            idx <= idx + 1'b1;
            state <= (idx + 1'b1) == count ? RESULT : ISSUE;
          end
        end
        RESULT: if (bus.res_ready) begin
          acc <= '0;
          idx <= '0;
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule
